aes_round_sequencer: RTL and testbench

Control FSM for the fine-grained multicycle AES-128 datapath (state register, key register, SubBytes/ShiftRows/MixColumns units, key-schedule unit, next-state mux). It accepts one plaintext/key pair per handshake and steps the datapath through SB, SR and MC phases for 10 rounds. It then holds the ciphertext on out_bus under a ready/valid output handshake. It replaces the datapath's free-running key register with explicit register enables.

---
 rtl/aes_ctrl_pkg.sv | 19 +
 rtl/aes_round_sequencer.sv | 108 ++++++++++
 tb/tb_aes_round_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared control definitions for the multicycle AES-128 datapath sequencer:
// FSM state encoding, next-state mux step codes and the supported round count.
package aes_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SR,
      MC,
      SB,
      DONE
   } aes_fsm_e;

   localparam logic [1:0] STEP_SB = 2'd0;
   localparam logic [1:0] STEP_SR = 2'd1;
   localparam logic [1:0] STEP_MC = 2'd2;

   localparam int AES128_ROUNDS = 10;

endpackage

// File: rtl/aes_round_sequencer.sv
// Control FSM for the fine-grained multicycle AES-128 datapath: walks each block
// through SB/SR/MC phases for ten rounds and holds the ciphertext under ready/valid.
import aes_ctrl_pkg::*;

module aes_round_sequencer #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       ready,
   input  logic       out_ready,
   output logic       valid,
   output logic       in_sel,
   output logic [1:0] round_step,
   output logic [3:0] round_index,
   output logic       ks_en,
   output logic       key_en,
   output logic       state_en,
   output logic       busy
);

   if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_rounds
      $error("aes_round_sequencer supports only NUM_ROUNDS = 10 (AES-128)");
   end

   localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

   aes_fsm_e   fsm;
   logic [3:0] rnd;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm <= IDLE;
         rnd <= 4'd0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  rnd <= 4'd1;
                  fsm <= SR;
               end
            end
            SR:   fsm <= MC;
            MC: begin
               rnd <= rnd + 4'd1;
               fsm <= SB;
            end
            SB:   fsm <= (rnd == LAST_RND) ? DONE : SR;
            DONE: begin
               if (out_ready) fsm <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   // The SB phase XORs the current round key before substitution, so the
   // round key pipeline runs one ahead: the accept cycle produces round key 1.
   always_comb begin
      ready       = 1'b0;
      valid       = 1'b0;
      busy        = 1'b0;
      in_sel      = 1'b0;
      round_step  = STEP_SB;
      round_index = 4'd0;
      ks_en       = 1'b0;
      key_en      = 1'b0;
      state_en    = 1'b0;
      if (!rst) begin
         busy = (fsm != IDLE);
         case (fsm)
            IDLE: begin
               ready = 1'b1;
               if (in_valid) begin
                  in_sel   = 1'b1;
                  state_en = 1'b1;
                  key_en   = 1'b1;
                  ks_en    = 1'b1;
               end
            end
            SR: begin
               round_step = STEP_SR;
               state_en   = 1'b1;
            end
            MC: begin
               round_step = STEP_MC;
               state_en   = 1'b1;
            end
            SB: begin
               round_step  = STEP_SB;
               state_en    = 1'b1;
               key_en      = 1'b1;
               ks_en       = 1'b1;
               round_index = rnd - 4'd1;
            end
            DONE: begin
               valid      = 1'b1;
               round_step = STEP_SR;
            end
            default: begin
               busy = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: drives a behavioural AES datapath from the
// sequencer controls and compares against a plain AES-128 encryption function.
module tb_aes_round_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         ready;
   logic         out_ready;
   logic         valid;
   logic         in_sel;
   logic [1:0]   round_step;
   logic [3:0]   round_index;
   logic         ks_en;
   logic         key_en;
   logic         state_en;
   logic         busy;

   aes_round_sequencer #(.NUM_ROUNDS(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .ready(ready),
      .out_ready(out_ready), .valid(valid), .in_sel(in_sel),
      .round_step(round_step), .round_index(round_index), .ks_en(ks_en),
      .key_en(key_en), .state_en(state_en), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // ---------------- AES helpers ----------------
   logic [7:0] sb_t [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] v);
      logic [7:0] inv, base, r;
      inv = 8'h01; base = v;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) inv = gmul(inv, base);
         base = gmul(base, base);
      end
      r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return r;
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb_t[gb(s, i)];
      return r;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(4*c+w) -: 8] = gb(s, 4*((c+w)%4)+w);
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
         r[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         r[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         r[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         r[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return r;
   endfunction

   function automatic logic [127:0] ks_step(input logic [127:0] k, input logic [3:0] idx);
      logic [31:0] w0, w1, w2, w3, t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) if (i < int'(idx)) rc = xt(rc);
      w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
      t  = {sb_t[w3[23:16]] ^ rc, sb_t[w3[15:8]], sb_t[w3[7:0]], sb_t[w3[31:24]]};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [127:0] s, rk;
      s = pt ^ key; rk = key;
      for (int r = 1; r <= 10; r++) begin
         s = shift_rows(sub_bytes(s));
         if (r < 10) s = mix_columns(s);
         rk = ks_step(rk, 4'(r - 1));
         s = s ^ rk;
      end
      return s;
   endfunction

   function automatic logic [127:0] r128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- datapath driven by the sequencer ----------------
   logic [127:0] din, kin, st_m, kr_m, out_bus;

   function automatic logic [127:0] dp_next(input logic [127:0] s, input logic [127:0] k,
                                            input logic [1:0] step);
      case (step)
         2'd0:    return sub_bytes(s ^ k);
         2'd1:    return shift_rows(s);
         2'd2:    return mix_columns(s);
         default: return 'x;
      endcase
   endfunction

   always @(posedge clk) begin
      if (state_en) st_m <= dp_next(in_sel ? din : st_m, in_sel ? kin : kr_m, round_step);
      if (key_en)   kr_m <= ks_en ? ks_step(in_sel ? kin : kr_m, round_index)
                                  : (in_sel ? kin : kr_m);
   end

   assign out_bus = shift_rows(st_m) ^ kr_m;

   // ---------------- expected control pattern ----------------
   logic [12:0] ctrl;
   assign ctrl = {ready, valid, busy, in_sel, round_step, round_index, ks_en, key_en, state_en};

   localparam logic [12:0] IDLE_V = {1'b1, 12'b0};

   // k = cycles since the accept edge; k >= 28 is the output hold phase
   function automatic logic [12:0] exp_ctrl(input int k);
      if (k == 0)  return {1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1};
      if (k >= 28) return {1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0};
      case ((k - 1) % 3)
         0:       return {1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'd0, 1'b0, 1'b0, 1'b1};
         1:       return {1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1};
         default: return {1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'(k / 3), 1'b1, 1'b1, 1'b1};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   // One full block: accept, 27 round cycles, `stall` extra output-hold cycles.
   task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                            input logic [127:0] ct, input int stall, input bit hold,
                            output int acc);
      int n, ken;
      n = 0;
      while (ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 128'(ready), 128'd1);
      din = p; kin = k; in_valid = 1'b1; out_ready = 1'b0; acc = cyc;
      #1 chk("accept_ctrl", 128'(ctrl), 128'(exp_ctrl(0)));
      ken = int'(key_en);
      for (int c = 1; c <= 27; c++) begin
         @(negedge clk);
         din = r128(); kin = r128();
         in_valid  = hold ? 1'b1 : 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         #1 chk($sformatf("round_ctrl[%0d]", c), 128'(ctrl), 128'(exp_ctrl(c)));
         ken += int'(key_en);
      end
      for (int j = 0; j <= stall; j++) begin
         @(negedge clk);
         out_ready = (j == stall);
         in_valid  = hold ? 1'b1 : 1'($urandom_range(0, 1));
         #1 chk("done_ctrl", 128'(ctrl), 128'(exp_ctrl(28)));
         chk("ciphertext", out_bus, ct);
         ken += int'(key_en);
      end
      chk("key_en_count", 128'(ken), 128'd10);
      @(negedge clk);
      #1 chk("ready_after_done", 128'({ready, busy, valid}), 128'(3'b100));
      in_valid = 1'b0;
   endtask

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      int           stall;
      bit           hold;
   } vec_t;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   initial begin
      vec_t tbl [6];
      int   acc, prev_acc, vcnt;

      for (int i = 0; i < 256; i++) sb_t[i] = sbox_calc(8'(i));

      tbl[0] = '{C1_KEY, C1_PT, C1_CT, 0, 1'b1};
      tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                 128'h3925841d02dc09fbdc118597196a0b32, 5, 1'b1};
      for (int i = 2; i < 6; i++) begin
         tbl[i].key   = r128();
         tbl[i].pt    = r128();
         tbl[i].ct    = aes_ref(tbl[i].key, tbl[i].pt);
         tbl[i].stall = int'($urandom_range(0, 3));
         tbl[i].hold  = 1'b0;
      end

      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; din = '0; kin = '0;
      repeat (3) @(negedge clk);
      #1 chk("reset_ctrl", 128'(ctrl), 128'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1 chk("idle_ctrl", 128'(ctrl), 128'(IDLE_V));
      @(negedge clk);

      prev_acc = 0;
      for (int i = 0; i < 6; i++) begin
         run_block(tbl[i].key, tbl[i].pt, tbl[i].ct, tbl[i].stall, tbl[i].hold, acc);
         if (i > 0) chk($sformatf("accept_spacing[%0d]", i), 128'(acc - prev_acc),
                        128'(29 + tbl[i-1].stall));
         prev_acc = acc;
      end

      // Abort a block with a reset pulse in its cycle 15.
      din = C1_PT; kin = C1_KEY; in_valid = 1'b1;
      vcnt = 0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1 vcnt += int'(valid);
      end
      chk("busy_before_abort", 128'(busy), 128'd1);
      rst = 1'b1; in_valid = 1'b1;
      #1 chk("rst_ctrl_midblock", 128'(ctrl), 128'd0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1 chk("ready_after_rst", 128'(ctrl), 128'(IDLE_V));
      for (int c = 0; c < 35; c++) begin
         @(negedge clk);
         #1 vcnt += int'(valid);
      end
      chk("no_valid_after_abort", 128'(vcnt), 128'd0);

      run_block(C1_KEY, C1_PT, C1_CT, 0, 1'b0, acc);
      chk("ref_model_c1", aes_ref(C1_KEY, C1_PT), C1_CT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
